fft_bitrev_reorder: RTL

FFT_BITREV_REORDER -- requirements
Module: fft_bitrev_reorder

---
 rtl/fft_bitrev_reorder.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: ping-pong buffer turning bit-reversed FFT frames into natural order with valid/ready output.
// Optional REORDER_DROP_CNT_EN adds a saturating 16-bit drop_count output.
module fft_bitrev_reorder #(
  parameter int FFT_N     = 1024,
  parameter int log_FFT_N = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_sof,
  input  logic [15:0] in_re,
  input  logic [15:0] in_im,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [15:0] out_re,
  output logic [15:0] out_im,
  output logic        out_sof,
  output logic        out_eof,
  output logic        frame_drop
`ifdef REORDER_DROP_CNT_EN
  ,output logic [15:0] drop_count
`endif
);
  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} w_st_t;
  typedef enum logic {R_IDLE, R_READ} r_st_t;
  localparam logic [log_FFT_N-1:0] LAST = log_FFT_N'(FFT_N - 1);
  localparam logic [log_FFT_N-1:0] ZERO = '0;
  logic [31:0] mem [2*FFT_N];
  w_st_t w_st_q, w_st_d;
  r_st_t r_st_q, r_st_d;
  logic [log_FFT_N-1:0] w_q, w_d, r_q, r_d;
  logic wb_q, wb_d, rb_q, rb_d;
  logic [1:0] full_q, full_d;
  logic drop_q, drop_d;
  logic ov_q, ov_d, sof_q, sof_d, eof_q, eof_d;
  logic [31:0] rd_q;
  logic we, re, clr, set, busy;
  logic [log_FFT_N:0] wa, ra;

  function automatic logic [log_FFT_N-1:0] bitrev(input logic [log_FFT_N-1:0] x);
    logic [log_FFT_N-1:0] y;
    for (int i = 0; i < log_FFT_N; i++) y[i] = x[log_FFT_N-1-i];
    return y;
  endfunction

  // The output register is the memory read register itself, so a stalled sample simply is not re-read.
  always_comb begin
    r_st_d = r_st_q;
    r_d = r_q;
    rb_d = rb_q;
    ov_d = ov_q;
    sof_d = sof_q;
    eof_d = eof_q;
    re = 1'b0;
    ra = {rb_q, r_q};
    clr = 1'b0;
    case (r_st_q)
      R_IDLE: begin
        if (full_q[rb_q]) begin
          r_st_d = R_READ;
          r_d = '0;
        end
      end
      default: begin
        if (ov_q && eof_q) begin
          if (out_ready) begin
            clr = 1'b1;
            rb_d = ~rb_q;
            if (full_q[~rb_q]) begin
              re = 1'b1;
              ra = {~rb_q, ZERO};
              r_d = log_FFT_N'(1);
              sof_d = 1'b1;
              eof_d = 1'b0;
            end else begin
              r_st_d = R_IDLE;
              r_d = '0;
              ov_d = 1'b0;
              sof_d = 1'b0;
              eof_d = 1'b0;
            end
          end
        end else if (!ov_q || out_ready) begin
          re = 1'b1;
          r_d = r_q + 1'b1;
          ov_d = 1'b1;
          sof_d = (r_q == ZERO);
          eof_d = (r_q == LAST);
        end
      end
    endcase
  end

  // A bank whose read completes this cycle counts as free for an arriving frame.
  assign busy = full_q[wb_q] && !(clr && (rb_q == wb_q));

  always_comb begin
    w_st_d = w_st_q;
    w_d = w_q;
    wb_d = wb_q;
    drop_d = 1'b0;
    we = 1'b0;
    set = 1'b0;
    wa = {wb_q, bitrev(w_q)};
    if (in_valid) begin
      if (in_sof) begin
        w_d = log_FFT_N'(1);
        wa = {wb_q, ZERO};
        w_st_d = busy ? W_DROP : W_FILL;
        drop_d = busy;
        we = !busy;
      end else if (w_st_q == W_FILL) begin
        we = 1'b1;
        w_d = w_q + 1'b1;
        if (w_q == LAST) begin
          set = 1'b1;
          wb_d = ~wb_q;
          w_st_d = W_IDLE;
        end
      end else if (w_st_q == W_DROP) begin
        w_d = w_q + 1'b1;
        w_st_d = (w_q == LAST) ? W_IDLE : W_DROP;
      end
    end
  end

  always_comb begin
    full_d = full_q;
    if (clr) full_d[rb_q] = 1'b0;
    if (set) full_d[wb_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= {in_re, in_im};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_st_q <= W_IDLE;
      r_st_q <= R_IDLE;
      w_q <= '0;
      r_q <= '0;
      wb_q <= 1'b0;
      rb_q <= 1'b0;
      full_q <= '0;
      drop_q <= 1'b0;
      ov_q <= 1'b0;
      sof_q <= 1'b0;
      eof_q <= 1'b0;
      rd_q <= '0;
    end else begin
      w_st_q <= w_st_d;
      r_st_q <= r_st_d;
      w_q <= w_d;
      r_q <= r_d;
      wb_q <= wb_d;
      rb_q <= rb_d;
      full_q <= full_d;
      drop_q <= drop_d;
      ov_q <= ov_d;
      sof_q <= sof_d;
      eof_q <= eof_d;
      if (re) rd_q <= mem[ra];
    end
  end

  assign out_valid = ov_q;
  assign out_re = rd_q[31:16];
  assign out_im = rd_q[15:0];
  assign out_sof = sof_q;
  assign out_eof = eof_q;
  assign frame_drop = drop_q;

`ifdef REORDER_DROP_CNT_EN
  logic [15:0] dc_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dc_q <= '0;
    else if (drop_q && dc_q != 16'hFFFF) dc_q <= dc_q + 16'd1;
  end
  assign drop_count = dc_q;
`endif
endmodule
